// File: rtl/cpu_run_controller.sv
// Host-side sequencer for the pipelined cpu: preloads IMEM/DMEM, pulses reset,
// runs the core for a programmed number of cycles and reads DMEM back.
module cpu_run_controller #(
  parameter int unsigned IMEM_DEPTH = 128,
  parameter int unsigned DMEM_DEPTH = 128,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [15:0]      cmd_addr,
  input  logic [63:0]      cmd_data,
  input  logic [CNT_W-1:0] cmd_cycles,
  input  logic             halt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] run_cycles,
  output logic             cpu_arst_n,
  output logic             cpu_enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_I    = 3'd1;
  localparam logic [2:0] S_WR_D    = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;
  localparam logic [2:0] S_CRST    = 3'd6;
  localparam logic [2:0] S_RUN     = 3'd7;

  localparam logic [1:0] OP_WR_I = 2'd0;
  localparam logic [1:0] OP_WR_D = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_RD   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] cyc_q, cyc_nxt;
  logic             rd_ok_q, rd_ok_nxt;
  logic             imem_ok, dmem_ok;

  logic             rsp_valid_nxt, done_nxt, err_nxt, arst_n_nxt, enable_nxt;
  logic [63:0]      rsp_data_nxt, addr_nxt, addr2_nxt, wdata2_nxt;
  logic [CNT_W-1:0] run_cycles_nxt;
  logic             wen_nxt, wen2_nxt, ren2_nxt;
  logic [31:0]      wdata_nxt;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign ren_ext   = 1'b0;

  assign imem_ok = 32'(cmd_addr) < IMEM_DEPTH;
  assign dmem_ok = 32'(cmd_addr) < DMEM_DEPTH;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cyc_nxt        = cyc_q;
    rd_ok_nxt      = rd_ok_q;
    rsp_valid_nxt  = rsp_valid;
    rsp_data_nxt   = rsp_data;
    done_nxt       = 1'b0;
    err_nxt        = err;
    run_cycles_nxt = run_cycles;
    arst_n_nxt     = 1'b1;
    enable_nxt     = 1'b0;
    wen_nxt        = 1'b0;
    wen2_nxt       = 1'b0;
    ren2_nxt       = 1'b0;
    addr_nxt       = addr_ext;
    wdata_nxt      = wdata_ext;
    addr2_nxt      = addr_ext_2;
    wdata2_nxt     = wdata_ext_2;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WR_I: begin
              state_nxt = S_WR_I;
              if (imem_ok) begin
                wen_nxt   = 1'b1;
                addr_nxt  = 64'({cmd_addr, 2'b00});
                wdata_nxt = cmd_data[31:0];
              end else begin
                err_nxt = 1'b1;
              end
            end
            OP_WR_D: begin
              state_nxt = S_WR_D;
              if (dmem_ok) begin
                wen2_nxt   = 1'b1;
                addr2_nxt  = 64'({cmd_addr, 3'b000});
                wdata2_nxt = cmd_data;
              end else begin
                err_nxt = 1'b1;
              end
            end
            OP_RD: begin
              state_nxt = S_RD_REQ;
              rd_ok_nxt = dmem_ok;
              if (dmem_ok) begin
                ren2_nxt  = 1'b1;
                addr2_nxt = 64'({cmd_addr, 3'b000});
              end else begin
                err_nxt = 1'b1;
              end
            end
            default: begin
              // A zero-length run completes immediately without touching the core
              if (cmd_cycles == '0) begin
                done_nxt       = 1'b1;
                run_cycles_nxt = '0;
              end else begin
                state_nxt  = S_CRST;
                cyc_nxt    = cmd_cycles;
                cnt_nxt    = '0;
                arst_n_nxt = 1'b0;
              end
            end
          endcase
        end
      end
      S_WR_I, S_WR_D: state_nxt = S_IDLE;
      S_RD_REQ:       state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        state_nxt     = S_RSP;
        rsp_valid_nxt = 1'b1;
        rsp_data_nxt  = rd_ok_q ? rdata_ext_2 : '0;
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_nxt     = S_IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      S_CRST: begin
        // Core reset is held across two cycles, then enable starts
        if (cnt == CNT_W'(1)) begin
          state_nxt  = S_RUN;
          cnt_nxt    = '0;
          enable_nxt = 1'b1;
        end else begin
          cnt_nxt    = cnt_inc;
          arst_n_nxt = 1'b0;
        end
      end
      S_RUN: begin
        cnt_nxt = cnt_inc;
        if (halt || cnt_inc == cyc_q) begin
          state_nxt      = S_IDLE;
          done_nxt       = 1'b1;
          run_cycles_nxt = cnt_inc;
        end else begin
          enable_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cyc_q       <= '0;
      rd_ok_q     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      run_cycles  <= '0;
      cpu_arst_n  <= 1'b0;
      cpu_enable  <= 1'b0;
      wen_ext     <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cyc_q       <= cyc_nxt;
      rd_ok_q     <= rd_ok_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      run_cycles  <= run_cycles_nxt;
      cpu_arst_n  <= arst_n_nxt;
      cpu_enable  <= enable_nxt;
      wen_ext     <= wen_nxt;
      addr_ext    <= addr_nxt;
      wdata_ext   <= wdata_nxt;
      wen_ext_2   <= wen2_nxt;
      ren_ext_2   <= ren2_nxt;
      addr_ext_2  <= addr2_nxt;
      wdata_ext_2 <= wdata2_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed vector table, reset corner cases and
// randomized transactions checked against a transaction-level model.
module tb_cpu_run_controller;

  localparam int unsigned IMEM_DEPTH = 128;
  localparam int unsigned DMEM_DEPTH = 128;
  localparam int unsigned CNT_W      = 32;

  logic             clk;
  logic             srst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [15:0]      cmd_addr;
  logic [63:0]      cmd_data;
  logic [CNT_W-1:0] cmd_cycles;
  logic             halt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic             busy, done, err;
  logic [CNT_W-1:0] run_cycles;
  logic             cpu_arst_n, cpu_enable;
  logic [63:0]      addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic             wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0]      wdata_ext;

  cpu_run_controller #(
    .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .srst(srst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_cycles(cmd_cycles),
    .halt(halt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .done(done), .err(err), .run_cycles(run_cycles),
    .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMEM SRAM stand-in (1-cycle read latency) plus per-cycle activity counters
  logic [63:0] sram [DMEM_DEPTH];
  int n_wen, n_wen2, n_ren2, n_en, n_arst, n_done, n_viol;
  logic [63:0] last_wen_addr, last_wen2_addr, last_ren2_addr, last_wen2_data;
  logic [31:0] last_wen_data;

  initial begin
    n_wen = 0; n_wen2 = 0; n_ren2 = 0; n_en = 0; n_arst = 0; n_done = 0; n_viol = 0;
  end

  always @(posedge clk) begin
    if (wen_ext_2) sram[addr_ext_2[9:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= sram[addr_ext_2[9:3]];
    if (wen_ext)   begin n_wen  <= n_wen + 1;  last_wen_addr  <= addr_ext;   last_wen_data  <= wdata_ext;   end
    if (wen_ext_2) begin n_wen2 <= n_wen2 + 1; last_wen2_addr <= addr_ext_2; last_wen2_data <= wdata_ext_2; end
    if (ren_ext_2) begin n_ren2 <= n_ren2 + 1; last_ren2_addr <= addr_ext_2; end
    if (cpu_enable)  n_en   <= n_en + 1;
    if (!cpu_arst_n) n_arst <= n_arst + 1;
    if (done)        n_done <= n_done + 1;
    if ((32'(wen_ext) + 32'(ren_ext) + 32'(wen_ext_2) + 32'(ren_ext_2) > 1) || ren_ext ||
        ((wen_ext || wen_ext_2 || ren_ext_2) && (cpu_enable || !cpu_arst_n)))
      n_viol <= n_viol + 1;
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [63:0] data;
    logic [31:0] cycles;
    int          halt_at;
    int          hold;
    logic        noise;
    logic        e_err;
    int          e_stb;
    logic [63:0] e_addr;
    logic [63:0] e_rsp;
    logic [31:0] e_run;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  function automatic vec_t mk(logic [1:0] op, logic [15:0] addr, logic [63:0] data,
                              logic [31:0] cyc, int h, int hold, logic e_err, int e_stb,
                              logic [63:0] e_addr, logic [63:0] e_rsp, logic [31:0] e_run);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.cycles = cyc; v.halt_at = h; v.hold = hold;
    v.noise = 1'b0; v.e_err = e_err; v.e_stb = e_stb; v.e_addr = e_addr; v.e_rsp = e_rsp;
    v.e_run = e_run;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input vec_t v);
    int n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    check("cmd_ready", 64'(cmd_ready), 64'(1));
    cmd_valid  = 1'b1;
    cmd_op     = v.op;
    cmd_addr   = v.addr;
    cmd_data   = v.data;
    cmd_cycles = v.cycles;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    int s_wen, s_wen2, s_ren2, s_en, s_arst, s_done, n, own, total;
    s_wen = n_wen; s_wen2 = n_wen2; s_ren2 = n_ren2;
    s_en = n_en; s_arst = n_arst; s_done = n_done;
    halt = (v.op != 2'd2) ? v.noise : 1'b0;
    do_cmd(v);
    own = 0;
    case (v.op)
      2'd0, 2'd1: begin
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        check("wr_back_to_idle", 64'(busy), 64'(0));
        own = (v.op == 2'd0) ? (n_wen - s_wen) : (n_wen2 - s_wen2);
        check("wr_strobe_cycles", 64'(own), 64'(v.e_stb));
        if (v.e_stb != 0 && v.op == 2'd0) begin
          check("imem_addr", last_wen_addr, v.e_addr);
          check("imem_wdata", 64'(last_wen_data), 64'(v.data[31:0]));
        end
        if (v.e_stb != 0 && v.op == 2'd1) begin
          check("dmem_addr", last_wen2_addr, v.e_addr);
          check("dmem_wdata", last_wen2_data, v.data);
        end
      end
      2'd3: begin
        n = 0;
        while (!rsp_valid && n < 10) begin tick(); n++; end
        check("rsp_valid_rise", 64'(rsp_valid), 64'(1));
        for (int k = 0; k < v.hold; k++) begin
          check("rsp_valid_hold", 64'(rsp_valid), 64'(1));
          check("rsp_data_hold", rsp_data, v.e_rsp);
          tick();
        end
        rsp_ready = 1'b1;
        check("rsp_data", rsp_data, v.e_rsp);
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(rsp_valid), 64'(0));
        check("rd_back_to_idle", 64'(busy), 64'(0));
        own = n_ren2 - s_ren2;
        check("rd_strobe_cycles", 64'(own), 64'(v.e_stb));
        if (v.e_stb != 0) check("rd_addr", last_ren2_addr, v.e_addr);
      end
      default: begin
        if (v.cycles == 0) begin
          check("zero_run_done_next", 64'(done), 64'(1));
          check("zero_run_idle", 64'(busy), 64'(0));
        end else begin
          n = 0;
          while (!cpu_enable && n < 10) begin tick(); n++; end
          check("enable_start", 64'(cpu_enable), 64'(1));
          if (v.halt_at > 0) begin
            for (int i = 1; i < v.halt_at; i++) tick();
            halt = 1'b1;
            tick();
            halt = 1'b0;
            check("enable_drop_halt", 64'(cpu_enable), 64'(0));
            check("done_on_halt", 64'(done), 64'(1));
          end
        end
        n = 0;
        while (!done && n < 300) begin tick(); n++; end
        check("run_done", 64'(done), 64'(1));
        check("run_cycles", 64'(run_cycles), 64'(v.e_run));
        check("run_enable_off", 64'(cpu_enable), 64'(0));
        tick();
        check("done_single", 64'(done), 64'(0));
        check("done_pulses", 64'(n_done - s_done), 64'(1));
        check("enable_cycles", 64'(n_en - s_en), 64'(v.e_run));
        check("arst_cycles", 64'(n_arst - s_arst), 64'((v.cycles != 0) ? 2 : 0));
      end
    endcase
    halt = 1'b0;
    total = (n_wen - s_wen) + (n_wen2 - s_wen2) + (n_ren2 - s_ren2);
    check("foreign_strobes", 64'(total - own), 64'(0));
    check("err", 64'(err), 64'(v.e_err));
  endtask

  vec_t tbl[12];
  logic [63:0] ref_dmem [DMEM_DEPTH];
  logic [15:0] written[$];

  initial begin
    vec_t v;
    logic m_err;
    srst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    cmd_cycles = '0; halt = 1'b0; rsp_ready = 1'b0;

    tbl[0]  = mk(2'd0, 16'd5,   64'h00A00093, 0,   0,   0, 1'b0, 1, 64'h14, 64'h0, 0);
    tbl[1]  = mk(2'd1, 16'd3,   64'h1234,     0,   0,   0, 1'b0, 1, 64'h18, 64'h0, 0);
    tbl[2]  = mk(2'd1, 16'd2,   64'hDEADBEEF, 0,   0,   0, 1'b0, 1, 64'h10, 64'h0, 0);
    tbl[3]  = mk(2'd3, 16'd2,   64'h0,        0,   0,   3, 1'b0, 1, 64'h10, 64'hDEADBEEF, 0);
    tbl[4]  = mk(2'd2, 16'd0,   64'h0,        10,  0,   0, 1'b0, 0, 64'h0,  64'h0, 10);
    tbl[5]  = mk(2'd2, 16'd0,   64'h0,        0,   0,   0, 1'b0, 0, 64'h0,  64'h0, 0);
    tbl[6]  = mk(2'd2, 16'd0,   64'h0,        100, 7,   0, 1'b0, 0, 64'h0,  64'h0, 7);
    tbl[7]  = mk(2'd2, 16'd0,   64'h0,        100, 100, 0, 1'b0, 0, 64'h0,  64'h0, 100);
    tbl[8]  = mk(2'd0, 16'd128, 64'h13,       0,   0,   0, 1'b1, 0, 64'h0,  64'h0, 0);
    tbl[9]  = mk(2'd3, 16'd128, 64'h0,        0,   0,   1, 1'b1, 0, 64'h0,  64'h0, 0);
    tbl[10] = mk(2'd1, 16'd3,   64'h55AA,     0,   0,   0, 1'b1, 1, 64'h18, 64'h0, 0);
    tbl[11] = mk(2'd3, 16'd3,   64'h0,        0,   0,   0, 1'b1, 1, 64'h18, 64'h55AA, 0);

    // Reset state
    tick(); tick();
    check("rst_arst_n_low", 64'(cpu_arst_n), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_strobes", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'(0));
    check("rst_outputs", 64'({rsp_valid, done, err, cpu_enable}), 64'(0));
    check("rst_run_cycles", 64'(run_cycles), 64'(0));
    srst = 1'b0;
    tick();
    check("arst_n_release", 64'(cpu_arst_n), 64'(1));

    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // Synchronous reset in the middle of a run
    do_cmd(mk(2'd2, 16'd0, 64'h0, 50, 0, 0, 1'b0, 0, 64'h0, 64'h0, 0));
    begin
      int n = 0;
      while (!cpu_enable && n < 10) begin tick(); n++; end
    end
    check("midrun_enable", 64'(cpu_enable), 64'(1));
    tick(); tick(); tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("midrun_rst_enable", 64'(cpu_enable), 64'(0));
    check("midrun_rst_busy", 64'(busy), 64'(0));
    check("midrun_rst_err", 64'(err), 64'(0));
    check("midrun_rst_arst", 64'(cpu_arst_n), 64'(0));
    check("midrun_rst_done", 64'(done), 64'(0));
    tick();
    check("midrun_arst_release", 64'(cpu_arst_n), 64'(1));
    check("midrun_enable_stays_off", 64'(cpu_enable), 64'(0));

    // Randomized transactions against a transaction-level model
    m_err = 1'b0;
    for (int t = 0; t < 40; t++) begin
      int r;
      logic oor;
      r   = int'($urandom_range(0, 9));
      oor = ($urandom_range(0, 7) == 0);
      v   = mk(2'd0, 16'd0, {$urandom, $urandom}, 0, 0, 0, 1'b0, 0, 64'h0, 64'h0, 0);
      v.noise = 1'($urandom_range(0, 1));
      if (r < 3) begin
        v.op   = 2'd0;
        v.addr = oor ? 16'(IMEM_DEPTH + $urandom_range(0, 1000)) : 16'($urandom_range(0, IMEM_DEPTH - 1));
        v.e_addr = 64'({v.addr, 2'b00});
      end else if (r < 6) begin
        v.op   = 2'd1;
        v.addr = oor ? 16'(DMEM_DEPTH + $urandom_range(0, 1000)) : 16'($urandom_range(0, DMEM_DEPTH - 1));
        v.e_addr = 64'({v.addr, 3'b000});
        if (!oor) begin
          ref_dmem[v.addr[6:0]] = v.data;
          written.push_back(v.addr);
        end
      end else if (r < 8) begin
        v.op = 2'd3;
        if (written.size() == 0) oor = 1'b1;
        v.addr = oor ? 16'(DMEM_DEPTH + $urandom_range(0, 1000))
                     : written[$urandom_range(0, written.size() - 1)];
        v.e_addr = 64'({v.addr, 3'b000});
        v.e_rsp  = oor ? 64'h0 : ref_dmem[v.addr[6:0]];
        v.hold   = int'($urandom_range(0, 3));
      end else begin
        v.op      = 2'd2;
        oor       = 1'b0;
        v.noise   = 1'b0;
        v.cycles  = $urandom_range(0, 20);
        v.halt_at = (v.cycles != 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, v.cycles)) : 0;
        v.e_run   = (v.halt_at != 0 && 32'(v.halt_at) < v.cycles) ? 32'(v.halt_at) : v.cycles;
      end
      m_err   = m_err | oor;
      v.e_err = m_err;
      v.e_stb = (v.op != 2'd2 && !oor) ? 1 : 0;
      apply(v);
    end

    check("strobe_exclusion", 64'(n_viol), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
